// File: rtl/score_pkg.sv
`default_nettype none
// score_pkg (rev 1.0): FSM states, request indices and counter-width helper
// shared by score_ctrl and btn_cond.
package score_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    CLR_ARM  = 2'd1,
    CLR_LOCK = 2'd2
  } state_t;

  localparam int REQ_HOME_UP  = 0;
  localparam int REQ_HOME_DN  = 1;
  localparam int REQ_GUEST_UP = 2;
  localparam int REQ_GUEST_DN = 3;
  localparam int NUM_REQ      = 4;

  // Bits needed to hold the values 0..n.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_cond.sv
`default_nettype none
// btn_cond (rev 1.0): 2-flop synchroniser, debounce filter and rising-edge
// pulse for one raw push button.
module btn_cond
  import score_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = cnt_w(DEBOUNCE_CYCLES);

  logic          sync1;
  logic          sync2;
  logic          level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
      // Any sample agreeing with the current level restarts the filter.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign rise = level & ~level_d;

endmodule
`default_nettype wire

// File: rtl/score_ctrl.sv
`default_nettype none
// score_ctrl (rev 1.0): debounced button scoreboard with round-robin access
// to a shared saturating +1/-1 unit and a long-press clear.
module score_ctrl
  import score_pkg::*;
#(
  parameter int BW              = 7,
  parameter int MAX_SCORE       = 99,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CLR_HOLD_CYCLES = 1024
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          home_up_i,
  input  logic          home_down_i,
  input  logic          guest_up_i,
  input  logic          guest_down_i,
  input  logic          clear_i,
  output logic [BW-1:0] home_score_o,
  output logic [BW-1:0] guest_score_o,
  output logic          update_o,
  output logic          sat_o,
  output logic          clr_o
);

  localparam int HW = cnt_w(CLR_HOLD_CYCLES);
  localparam int NB = NUM_REQ + 1;

  logic [NB-1:0] raw;
  logic [NB-1:0] btn_lvl;
  logic [NB-1:0] btn_rise;
  logic          unused_lvl;
  logic          clr_lvl;

  // Clear button sits above the four request buttons.
  assign raw = {clear_i, guest_down_i, guest_up_i, home_down_i, home_up_i};

  generate
    for (genvar i = 0; i < NB; i++) begin : g_btn
      btn_cond #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_btn (
        .clk  (clk_i),
        .rst_n(rst_n_i),
        .raw  (raw[i]),
        .level(btn_lvl[i]),
        .rise (btn_rise[i])
      );
    end
  endgenerate

  assign unused_lvl = ^btn_lvl[NUM_REQ-1:0];
  assign clr_lvl    = btn_lvl[NUM_REQ];

  state_t               state;
  logic [NUM_REQ-1:0]   pending;
  logic [1:0]           ptr;
  logic [HW-1:0]        hold_cnt;

  logic                 gnt_valid;
  logic [1:0]           gnt_idx;
  logic [1:0]           cand;
  logic [NUM_REQ-1:0]   gnt_mask;

  // Scan downward so the candidate closest to ptr is the one that sticks.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = ptr;
    cand      = ptr;
    if (state != CLR_LOCK) begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        cand = ptr + 2'(i);
        if (pending[cand]) begin
          gnt_valid = 1'b1;
          gnt_idx   = cand;
        end
      end
    end
  end

  assign gnt_mask = gnt_valid ? (NUM_REQ'(1) << gnt_idx) : '0;

  logic          is_up;
  logic          can_move;
  logic [BW-1:0] cur;
  logic [BW-1:0] nxt;

  assign is_up    = ~gnt_idx[0];
  assign cur      = gnt_idx[1] ? guest_score_o : home_score_o;
  assign can_move = is_up ? (cur < BW'(MAX_SCORE)) : (cur != '0);
  assign nxt      = cur + (is_up ? BW'(1) : {BW{1'b1}});

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state         <= RUN;
      pending       <= '0;
      ptr           <= '0;
      hold_cnt      <= '0;
      home_score_o  <= '0;
      guest_score_o <= '0;
      update_o      <= 1'b0;
      sat_o         <= 1'b0;
      clr_o         <= 1'b0;
    end else begin
      update_o <= 1'b0;
      sat_o    <= 1'b0;
      clr_o    <= 1'b0;

      if (gnt_valid) begin
        ptr <= gnt_idx + 2'd1;
        if (can_move) begin
          update_o <= 1'b1;
          if (gnt_idx[1]) guest_score_o <= nxt;
          else            home_score_o  <= nxt;
        end else begin
          sat_o <= 1'b1;
        end
      end

      if (state != CLR_LOCK) begin
        pending <= (pending | btn_rise[NUM_REQ-1:0]) & ~gnt_mask;
      end

      case (state)
        RUN: begin
          if (btn_rise[NUM_REQ]) begin
            state    <= CLR_ARM;
            hold_cnt <= '0;
          end
        end
        CLR_ARM: begin
          if (!clr_lvl) begin
            state <= RUN;
          end else if (hold_cnt == HW'(CLR_HOLD_CYCLES - 1)) begin
            // The clear wins over any grant taken on the same edge.
            state         <= CLR_LOCK;
            home_score_o  <= '0;
            guest_score_o <= '0;
            pending       <= '0;
            ptr           <= '0;
            update_o      <= 1'b0;
            sat_o         <= 1'b0;
            clr_o         <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        CLR_LOCK: begin
          if (!clr_lvl) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_score_ctrl.sv
`default_nettype none
// tb_score_ctrl (rev 1.0): table, directed and random checks of score_ctrl
// against a press-level scoreboard model.
module tb_score_ctrl;

  localparam int BW   = 7;
  localparam int MAXS = 99;
  localparam int DEB  = 4;
  localparam int HOLD = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hu = 1'b0, hd = 1'b0, gu = 1'b0, gd = 1'b0, clr = 1'b0;
  logic [BW-1:0] home, guest;
  logic upd, sat, clro;

  score_ctrl #(
    .BW(BW), .MAX_SCORE(MAXS), .DEBOUNCE_CYCLES(DEB), .CLR_HOLD_CYCLES(HOLD)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .home_up_i    (hu),
    .home_down_i  (hd),
    .guest_up_i   (gu),
    .guest_down_i (gd),
    .clear_i      (clr),
    .home_score_o (home),
    .guest_score_o(guest),
    .update_o     (upd),
    .sat_o        (sat),
    .clr_o        (clro)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_upd = 0, n_sat = 0, n_clr = 0;
  logic [2*BW-1:0] trace[$];
  logic [2*BW-1:0] last_pair = '0;

  always @(negedge clk) begin
    if (upd === 1'b1) n_upd++;
    if (sat === 1'b1) n_sat++;
    if (clro === 1'b1) n_clr++;
    if ({home, guest} !== last_pair) begin
      trace.push_back({home, guest});
      last_pair = {home, guest};
    end
  end

  // Press-level model: each pressed button is served once, in cyclic order
  // starting after the last served button.
  int m_home, m_guest, m_ptr, m_upd, m_sat;

  task automatic model_reset();
    m_home = 0; m_guest = 0; m_ptr = 0;
  endtask

  task automatic model_press(input logic [3:0] mask);
    int start;
    start = m_ptr;
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (start + k) % 4;
      if (mask[idx]) begin
        case (idx)
          0: if (m_home < MAXS) begin m_home++; m_upd++; end else m_sat++;
          1: if (m_home > 0) begin m_home--; m_upd++; end else m_sat++;
          2: if (m_guest < MAXS) begin m_guest++; m_upd++; end else m_sat++;
          default: if (m_guest > 0) begin m_guest--; m_upd++; end else m_sat++;
        endcase
        m_ptr = (idx + 1) % 4;
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    {gd, gu, hd, hu} = 4'b0;
    clr = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    model_reset();
  endtask

  task automatic press(input logic [3:0] mask, input int hold, input int gap);
    {gd, gu, hd, hu} = mask;
    repeat (hold) tick();
    {gd, gu, hd, hu} = 4'b0;
    repeat (gap) tick();
  endtask

  task automatic press_n(input logic [3:0] mask, input int n);
    for (int k = 0; k < n; k++) begin
      press(mask, 8, 8);
      model_press(mask);
    end
  endtask

  task automatic press_check(input string name, input logic [3:0] mask);
    int u0, s0, mu0, ms0;
    u0 = n_upd; s0 = n_sat; mu0 = m_upd; ms0 = m_sat;
    press(mask, 8, 14);
    model_press(mask);
    check({name, ".home"}, int'(home), m_home);
    check({name, ".guest"}, int'(guest), m_guest);
    check({name, ".upd"}, n_upd - u0, m_upd - mu0);
    check({name, ".sat"}, n_sat - s0, m_sat - ms0);
  endtask

  typedef struct {
    logic [3:0] mask;
    int         home;
    int         guest;
    int         upd;
    int         sat;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int u0, s0, c0, base;
    logic [2*BW-1:0] exp_tr[4];

    tbl[0] = '{4'b0001, 1, 0, 1, 0};
    tbl[1] = '{4'b0010, 0, 0, 1, 0};
    tbl[2] = '{4'b0010, 0, 0, 0, 1};
    tbl[3] = '{4'b1000, 0, 0, 0, 1};
    tbl[4] = '{4'b0100, 0, 1, 1, 0};
    tbl[5] = '{4'b0101, 1, 2, 2, 0};
    tbl[6] = '{4'b0011, 1, 2, 2, 0};
    tbl[7] = '{4'b1111, 1, 2, 4, 0};
    m_upd = 0; m_sat = 0;
    model_reset();

    // Reset state
    repeat (2) tick();
    check("rst.home", int'(home), 0);
    check("rst.guest", int'(guest), 0);
    check("rst.upd", int'(upd), 0);
    check("rst.sat", int'(sat), 0);
    check("rst.clr", int'(clro), 0);
    rst_n = 1'b1;
    tick();

    // Table vectors from a fresh reset
    for (int v = 0; v < 8; v++) begin
      u0 = n_upd; s0 = n_sat;
      press(tbl[v].mask, 10, 14);
      model_press(tbl[v].mask);
      check($sformatf("tbl%0d.home", v), int'(home), tbl[v].home);
      check($sformatf("tbl%0d.guest", v), int'(guest), tbl[v].guest);
      check($sformatf("tbl%0d.upd", v), n_upd - u0, tbl[v].upd);
      check($sformatf("tbl%0d.sat", v), n_sat - s0, tbl[v].sat);
    end

    // Short glitches never get through the debounce filter
    u0 = n_upd; s0 = n_sat;
    for (int k = 0; k < 5; k++) press(4'b0100, 3, 3);
    repeat (10) tick();
    check("glitch.guest", int'(guest), 2);
    check("glitch.upd", n_upd - u0, 0);
    check("glitch.sat", n_sat - s0, 0);

    // Simultaneous presses from 5/5 are served HU, HD, GU, GD
    do_reset();
    press_n(4'b0001, 5);
    press_n(4'b0100, 6);
    press_n(4'b1000, 1);
    check("rr.pre_home", int'(home), 5);
    check("rr.pre_guest", int'(guest), 5);
    base = trace.size();
    u0 = n_upd;
    press(4'b1111, 8, 14);
    model_press(4'b1111);
    exp_tr[0] = {7'd6, 7'd5};
    exp_tr[1] = {7'd5, 7'd5};
    exp_tr[2] = {7'd5, 7'd6};
    exp_tr[3] = {7'd5, 7'd5};
    check("rr.changes", trace.size() - base, 4);
    for (int k = 0; k < 4; k++)
      if (base + k < trace.size())
        check($sformatf("rr.step%0d", k), int'(trace[base+k]), int'(exp_tr[k]));
    check("rr.upd", n_upd - u0, 4);

    // Upper limit, then random presses around it
    press_n(4'b0001, 94);
    check("sat.pre_home", int'(home), 99);
    press_check("sat.hu99", 4'b0001);
    for (int r = 0; r < 40; r++)
      press_check($sformatf("rnd%0d", r), 4'($urandom_range(1, 15)));

    // Lower limit on guest
    do_reset();
    press_check("sat.gd0", 4'b1000);

    // Long-press clear
    do_reset();
    press_n(4'b0001, 42);
    press_n(4'b0100, 17);
    check("clr.pre_home", int'(home), 42);
    check("clr.pre_guest", int'(guest), 17);
    c0 = n_clr;
    clr = 1'b1;
    repeat (6) tick();
    clr = 1'b0;
    repeat (14) tick();
    check("clr.short_home", int'(home), 42);
    check("clr.short_guest", int'(guest), 17);
    check("clr.short_pulse", n_clr - c0, 0);
    u0 = n_upd;
    clr = 1'b1;
    repeat (18) tick();
    hu = 1'b1;
    repeat (8) tick();
    hu = 1'b0;
    repeat (4) tick();
    clr = 1'b0;
    repeat (20) tick();
    check("clr.home", int'(home), 0);
    check("clr.guest", int'(guest), 0);
    check("clr.pulse", n_clr - c0, 1);
    check("clr.lock_upd", n_upd - u0, 0);

    // Asynchronous reset with a request pending
    do_reset();
    press_n(4'b0001, 30);
    check("arst.pre_home", int'(home), 30);
    u0 = n_upd;
    hu = 1'b1;
    repeat (7) tick();
    #3;
    rst_n = 1'b0;
    #1;
    check("arst.home_now", int'(home), 0);
    check("arst.guest_now", int'(guest), 0);
    hu = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (15) tick();
    check("arst.home_after", int'(home), 0);
    check("arst.upd_after", n_upd - u0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/score_ctrl.md
Name: score_ctrl

Overview:
- Single-clock scoreboard controller. It takes four raw push-button inputs (home up/down, guest up/down) and a clear button.
- It synchronises and debounces every button, turns each press into a pending request, and arbitrates the requests round-robin onto one shared saturating +1/-1 unit.
- It holds the two 0..MAX_SCORE score registers that drive the 7-segment display path, and supports a long-press clear of both scores.

Parameters:
- BW, 7, score width in bits.
- MAX_SCORE, 99, upper saturation limit (must be < 2**BW).
- DEBOUNCE_CYCLES, 16, number of consecutive stable synchronised samples needed to accept a new button level.
- CLR_HOLD_CYCLES, 1024, number of cycles the debounced clear must stay high before the clear fires.

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  asynchronous, active-low reset.
- home_up_i  in  1  raw button, asynchronous to clk_i.
- home_down_i  in  1  raw button.
- guest_up_i  in  1  raw button.
- guest_down_i  in  1  raw button.
- clear_i  in  1  raw clear button.
- home_score_o  out  BW  home score, 0..MAX_SCORE.
- guest_score_o  out  BW  guest score, 0..MAX_SCORE.
- update_o  out  1  one-cycle pulse: a score register changed in the previous cycle.
- sat_o  out  1  one-cycle pulse: a granted request was discarded at a limit.
- clr_o  out  1  one-cycle pulse: a clear fired.

Behaviour:
- Reset: one clock, clk_i. Reset is asynchronous and active-low (rst_n_i). While rst_n_i=0:
  - all scores are 0;
  - update_o, sat_o and clr_o are 0;
  - all synchroniser, debounce, pending and pointer state is 0;
  - the FSM is in RUN.
- Input conditioning (identical for all 5 buttons):
  - 2-flop synchroniser;
  - debounce counter: the debounced level changes only after DEBOUNCE_CYCLES consecutive samples that differ from the current debounced level;
  - any sample equal to the current level resets the counter.
- Request capture:
  - A rising edge of a debounced up/down level sets that button's pending bit, in the cycle after the debounced level rises.
  - A rising edge while the pending bit is already set is dropped.
- Arbiter / shared unit:
  - Each cycle in RUN or CLR_ARM with any pending bit set, grant exactly one request.
  - Priority is round-robin in the fixed order home_up, home_down, guest_up, guest_down, starting after the last grant; the pointer resets to home_up.
  - On the granting edge: the granted pending bit clears and the target score updates via a single shared adder.
  - up: score+1 if score < MAX_SCORE, otherwise unchanged.
  - down: score-1 if score > 0, otherwise unchanged.
  - update_o=1 in the next cycle if the score changed; otherwise sat_o=1 in the next cycle.
  - Grant-to-score latency is 1 edge.
  - Up and down pending for the same team are served in successive grants, giving net 0 unless saturated. No wrap-around, ever.
- FSM states:
  - RUN: enter CLR_ARM when the debounced clear rises.
  - CLR_ARM: hold counter increments each cycle. If the debounced clear falls, return to RUN (no clear). If the counter reaches CLR_HOLD_CYCLES, then on that edge: both scores=0, all pending bits=0, pointer=home_up, clr_o=1 next cycle, enter CLR_LOCK.
  - CLR_LOCK: no grants; new edges are ignored (not captured). Return to RUN when the debounced clear is low.
- Reset asserted mid-operation: all state returns to reset values immediately; pending requests are lost.

Decomposition:
- Shared package score_pkg holds:
  - the FSM state enum (RUN, CLR_ARM, CLR_LOCK);
  - request index constants REQ_HOME_UP=0, REQ_HOME_DN=1, REQ_GUEST_UP=2, REQ_GUEST_DN=3, NUM_REQ=4;
  - a clog2-based width helper for the debounce and hold counters.
- One sub-module, btn_cond (synchroniser + debounce + rising-edge pulse), instantiated 5 times.
- Arbiter, shared adder and FSM stay in score_ctrl.

Test Plan (DEBOUNCE_CYCLES=4, CLR_HOLD_CYCLES=8):
1. Reset, then hold home_up_i high 10 cycles -> home_score_o 0->1 exactly once, one update_o pulse, guest_score_o stays 0.
2. Glitch guest_up_i high for 3 cycles, repeat 5 times with 3-cycle gaps -> no score change, no pulses.
3. Press home_up, home_down, guest_up and guest_down in the same cycle from home=5, guest=5 -> grants on 4 consecutive cycles in order HU, HD, GU, GD; final scores 5/5; 4 update_o pulses.
4. Home at 99, press home_up -> score stays 99, sat_o pulses once. Guest at 0, press guest_down -> score stays 0, sat_o pulses once.
5. Scores 42/17: hold clear_i for 6 debounced cycles -> no clear. Hold 20 cycles -> both scores 0, clr_o pulses once. A home_up press during the hold-over is ignored.
6. Assert rst_n_i asynchronously (mid-cycle) while a request is pending with score 30 -> outputs are 0 immediately and no grant occurs after release.
